// File: rtl/shift_pipe.sv
// shift_pipe: pipelined WIDTH-bit barrel shifter with logical, arithmetic and
// rotate modes, out-of-range amount handling and a rounding sticky bit,
// wrapped in a valid/ready stage chain of PIPE (1 or 2) registers.
//
// Optional feature macro: SHIFT_PIPE_STICKY_EN
//   defined   - sticky logic and its per-stage registers are built.
//   undefined - o_sticky is tied to 0; the data path is identical.
//
// All shifting happens on one left ladder. Right shifts reverse the operand
// before the ladder and reverse the result after it. The upper ceil(AMT_W/2)
// ladder levels sit in front of stage 0 when PIPE=2; the lower levels feed
// the output register.
module shift_pipe #(
  parameter int WIDTH = 48,
  parameter int AMT_W = 6,
  parameter int PIPE  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_left,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sticky
);

  localparam int HI = (AMT_W + 1) / 2;  // levels applied before stage 0
  localparam int LO = AMT_W - HI;       // levels applied before the output
  localparam logic [AMT_W:0] WIDTH_X = (AMT_W + 1)'(WIDTH);

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Operand state between the upper and lower halves of the ladder.
  typedef struct packed {
    logic [WIDTH-1:0] x;       // partially shifted, in left-ladder bit order
    logic [LO-1:0]    amt_lo;  // amount bits still to apply
    logic             fill;    // bit shifted in at the bottom
    logic             rot;     // rotate: wrap top bits instead of filling
    logic             left;    // undo bit reversal at the output when 0
    logic             ovr;     // out-of-range non-rotate: result is all fill
  } mid_t;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // One ladder level: shift left by s, bringing in either the fill bit or
  // the bits that fell off the top (rotate). s is always below WIDTH.
  function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] x,
                                           input logic fill, input logic rot,
                                           input int s);
    logic [WIDTH-1:0] lo_mask;
    lo_mask = ~({WIDTH{1'b1}} << s);
    return (x << s) | (rot ? (x >> (WIDTH - s)) : ({WIDTH{fill}} & lo_mask));
  endfunction

  // Bits a level of size s pushes out of the top of the ladder.
  function automatic logic lost(input logic [WIDTH-1:0] x, input int s);
    return |(x >> (WIDTH - s));
  endfunction

  // ---------------------------------------------------------------- decode
  logic             f_rot;
  logic             f_arith;
  logic             f_fill;
  logic             f_oor;
  logic [AMT_W:0]   f_amt_x;
  logic [AMT_W-1:0] f_eff;

  assign f_rot   = (i_mode == MODE_ROT);
  assign f_arith = (i_mode == MODE_ARITH) && !i_left;
  assign f_fill  = f_arith && i_data[WIDTH-1];
  assign f_amt_x = {1'b0, i_amt};
  assign f_oor   = (f_amt_x >= WIDTH_X);
  // 2^AMT_W < 2*WIDTH, so one subtraction brings any rotate amount in range.
  assign f_eff   = (f_rot && f_oor) ? AMT_W'(f_amt_x - WIDTH_X) : i_amt;

  mid_t front;
  mid_t mid;
  logic mid_valid;
  logic adv_out;

`ifdef SHIFT_PIPE_STICKY_EN
  logic front_sticky;
  logic mid_sticky;
  logic back_sticky;
`endif

  // Upper half of the ladder on the incoming operand.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned, which would infer a latch.
    front = '0;
`ifdef SHIFT_PIPE_STICKY_EN
    front_sticky = 1'b0;
`endif
    front.x = i_left ? i_data : bit_rev(i_data);
    for (int k = AMT_W - 1; k >= LO; k--) begin
      if (f_eff[k]) begin
`ifdef SHIFT_PIPE_STICKY_EN
        if (!f_rot) front_sticky = front_sticky | lost(front.x, 1 << k);
`endif
        front.x = lvl(front.x, f_fill, f_rot, 1 << k);
      end
    end
    front.amt_lo = f_eff[LO-1:0];
    front.fill   = f_fill;
    front.rot    = f_rot;
    front.left   = i_left;
    front.ovr    = f_oor && !f_rot;
`ifdef SHIFT_PIPE_STICKY_EN
    // Everything is shifted out, so sticky covers the whole operand.
    if (front.ovr) front_sticky = |i_data;
`endif
  end

  logic [WIDTH-1:0] back_x;
  logic [WIDTH-1:0] back_data;

  // Lower half of the ladder, output reversal and out-of-range override.
  always_comb begin
    back_x = mid.x;
`ifdef SHIFT_PIPE_STICKY_EN
    back_sticky = mid_sticky;
`endif
    for (int k = LO - 1; k >= 0; k--) begin
      if (mid.amt_lo[k]) begin
`ifdef SHIFT_PIPE_STICKY_EN
        if (!mid.rot && !mid.ovr) back_sticky = back_sticky | lost(back_x, 1 << k);
`endif
        back_x = lvl(back_x, mid.fill, mid.rot, 1 << k);
      end
    end
    back_data = mid.ovr ? {WIDTH{mid.fill}} : (mid.left ? back_x : bit_rev(back_x));
  end

  // Output stage can load when it is empty or its result is being taken.
  assign adv_out = !o_valid || i_ready;

  if (PIPE == 2) begin : g_two
    logic s0_valid;
    logic adv0;
    mid_t s0_q;

    assign adv0      = !s0_valid || adv_out;
    assign o_ready   = adv0;
    assign mid_valid = s0_valid;
    assign mid       = s0_q;

    // Stage 0: capture the half-shifted operand on every advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the values from before this clock edge.
      if (!i_rst_n) begin
        s0_valid <= 1'b0;
        s0_q     <= '0;
      end else begin
        if (adv0) s0_valid <= i_valid;
        if (adv0 && i_valid) s0_q <= front;
      end
    end

`ifdef SHIFT_PIPE_STICKY_EN
    logic s0_sticky;
    assign mid_sticky = s0_sticky;

    // Stage 0 partial sticky travels alongside the operand.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) s0_sticky <= 1'b0;
      else if (adv0 && i_valid) s0_sticky <= front_sticky;
    end
`endif
  end else begin : g_one
    assign o_ready   = adv_out;
    assign mid_valid = i_valid;
    assign mid       = front;
`ifdef SHIFT_PIPE_STICKY_EN
    assign mid_sticky = front_sticky;
`endif
  end

  // Output register: loads only on a real transfer, holds under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      if (adv_out) o_valid <= mid_valid;
      if (adv_out && mid_valid) o_data <= back_data;
    end
  end

`ifdef SHIFT_PIPE_STICKY_EN
  // Output sticky register follows o_data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_sticky <= 1'b0;
    else if (adv_out && mid_valid) o_sticky <= back_sticky;
  end
`else
  assign o_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, backpressure,
// reset handling and randomized traffic against a word-level model.
module tb_shift_pipe;

  localparam int WIDTH = 48;
  localparam int AMT_W = 6;
  localparam int PIPE  = 2;
`ifdef SHIFT_PIPE_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [WIDTH-1:0] i_data = '0;
  logic [AMT_W-1:0] i_amt = '0;
  logic             i_left = 1'b0;
  logic [1:0]       i_mode = 2'b00;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic             o_sticky;

  always #5 i_clk = ~i_clk;

  shift_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W), .PIPE(PIPE)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_amt   (i_amt),
    .i_left  (i_left),
    .i_mode  (i_mode),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sticky(o_sticky)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             s;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;
  int               acc_cyc = 0;
  int               out_cyc = 0;
  int               n_out = 0;
  bit               in_fire_q = 1'b0;
  logic [WIDTH-1:0] exp_d = '0;
  logic             exp_s = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic stk(input logic s);
    return s & STICKY_ON;
  endfunction

  // Word-level reference: shifts on a double-width word, rotate by modulo.
  function automatic exp_t model(input logic [WIDTH-1:0] d, input int amt,
                                 input logic left, input logic [1:0] mode);
    exp_t               r;
    logic [2*WIDTH-1:0] w;
    int                 e;
    if (mode == 2'b10) begin
      e = amt % WIDTH;
      w = {d, d};
      if (left) r.d = w[2*WIDTH-1-e -: WIDTH];
      else      r.d = w[e +: WIDTH];
      r.s = 1'b0;
    end else if (amt >= WIDTH) begin
      r.d = (mode == 2'b01 && !left) ? {WIDTH{d[WIDTH-1]}} : '0;
      r.s = |d;
    end else if (left) begin
      w   = {{WIDTH{1'b0}}, d} << amt;
      r.d = w[WIDTH-1:0];
      r.s = |w[2*WIDTH-1:WIDTH];
    end else begin
      w = {d, {WIDTH{1'b0}}};
      if (mode == 2'b01) w = $signed(w) >>> amt;
      else               w = w >> amt;
      r.d = w[2*WIDTH-1:WIDTH];
      r.s = |w[WIDTH-1:0];
    end
    r.s = r.s & STICKY_ON;
    return r;
  endfunction

  // One clock: score outputs and accepted inputs at the falling edge,
  // then return 1 time unit after the rising edge for the next drive.
  task automatic step();
    exp_t e;
    @(negedge i_clk);
    in_fire_q = 1'b0;
    if (i_rst_n) begin
      if (o_valid && i_ready) begin
        n_out++;
        out_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(o_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("data", 64'(o_data), 64'(e.d));
          check("sticky", 64'(o_sticky), 64'(e.s));
        end
      end
      if (i_valid && o_ready) begin
        in_fire_q = 1'b1;
        acc_cyc   = cyc;
        e.d       = exp_d;
        e.s       = exp_s;
        sb.push_back(e);
      end
    end
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  // Present one transaction and hold it until accepted; valid stays high.
  task automatic send(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                      input logic l, input logic [1:0] m,
                      input logic [WIDTH-1:0] ed, input logic es);
    i_valid = 1'b1;
    i_data  = d;
    i_amt   = a;
    i_left  = l;
    i_mode  = m;
    exp_d   = ed;
    exp_s   = stk(es);
    for (int g = 0; g < 20; g++) begin
      step();
      if (in_fire_q) break;
    end
    if (!in_fire_q) check("accept_timeout", 64'(in_fire_q), 64'd1);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int g = 0; g < 50 && sb.size() > 0; g++) step();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    int   n0;
    bit   pend;
    logic [63:0] rnd;

    // Reset held with valid asserted.
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_data  = 48'hFFFF_FFFF_FFFF;
    i_amt   = 6'd3;
    repeat (3) step();
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_data", 64'(o_data), 64'd0);
    check("rst_o_sticky", 64'(o_sticky), 64'd0);
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    step();

    // First result latency, left logical.
    send(48'h8000_0000_0001, 6'd1, 1'b1, 2'b00, 48'h0000_0000_0002, 1'b1);
    i_valid = 1'b0;
    n0 = n_out;
    for (int g = 0; g < 10 && n_out == n0; g++) step();
    check("first_latency", 64'(out_cyc - acc_cyc), 64'(PIPE));

    // Directed vectors, streamed back to back.
    send(48'h8000_0000_0001, 6'd1,  1'b0, 2'b00, 48'h4000_0000_0000, 1'b1);
    send(48'h8000_0000_0001, 6'd52, 1'b0, 2'b00, 48'h0000_0000_0000, 1'b1);
    send(48'h8000_0000_0000, 6'd4,  1'b0, 2'b01, 48'hF800_0000_0000, 1'b0);
    send(48'h8000_0000_0000, 6'd50, 1'b0, 2'b01, 48'hFFFF_FFFF_FFFF, 1'b1);
    send(48'h8000_0000_0001, 6'd1,  1'b1, 2'b10, 48'h0000_0000_0003, 1'b0);
    send(48'h8000_0000_0001, 6'd49, 1'b1, 2'b10, 48'h0000_0000_0003, 1'b0);
    send(48'h8000_0000_0001, 6'd1,  1'b0, 2'b10, 48'hC000_0000_0000, 1'b0);
    send(48'h0000_0000_0001, 6'd48, 1'b1, 2'b00, 48'h0000_0000_0000, 1'b1);
    send(48'hFFFF_FFFF_FFFF, 6'd0,  1'b0, 2'b00, 48'hFFFF_FFFF_FFFF, 1'b0);
    send(48'h8000_0000_0001, 6'd47, 1'b1, 2'b00, 48'h8000_0000_0000, 1'b1);
    send(48'h8000_0000_0001, 6'd1,  1'b1, 2'b01, 48'h0000_0000_0002, 1'b1);
    send(48'h8000_0000_0000, 6'd4,  1'b0, 2'b11, 48'h0800_0000_0000, 1'b0);
    send(48'h8000_0000_0003, 6'd47, 1'b0, 2'b01, 48'hFFFF_FFFF_FFFF, 1'b1);
    drain();

    // Backpressure: fill the pipe, stall three cycles, then release.
    n0 = n_out;
    i_ready = 1'b0;
    send(48'h1, 6'd0, 1'b1, 2'b00, 48'h1, 1'b0);
    send(48'h1, 6'd1, 1'b1, 2'b00, 48'h2, 1'b0);
    i_amt = 6'd2;
    exp_d = 48'h4;
    exp_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ready_low", 64'(o_ready), 64'd0);
      check("bp_valid_held", 64'(o_valid), 64'd1);
      check("bp_data_held", 64'(o_data), 64'h1);
    end
    i_ready = 1'b1;
    send(48'h1, 6'd2, 1'b1, 2'b00, 48'h4, 1'b0);
    send(48'h1, 6'd3, 1'b1, 2'b00, 48'h8, 1'b0);
    drain();
    check("bp_out_count", 64'(n_out - n0), 64'd4);

    // Reset with two transactions in flight.
    i_ready = 1'b0;
    send(48'h1234_5678_9ABC, 6'd5, 1'b1, 2'b00, 48'h0, 1'b0);
    send(48'h0F0F_0F0F_0F0F, 6'd7, 1'b0, 2'b00, 48'h0, 1'b0);
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid_drop", 64'(o_valid), 64'd0);
    sb.delete();
    repeat (2) step();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    n0 = n_out;
    repeat (6) step();
    check("midrst_no_output", 64'(n_out - n0), 64'd0);
    check("midrst_valid_low", 64'(o_valid), 64'd0);

    // Randomized traffic with random backpressure.
    pend = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (!pend) begin
        if ($urandom_range(0, 9) < 7) begin
          rnd     = {$urandom(), $urandom()};
          i_data  = rnd[WIDTH-1:0];
          if ($urandom_range(0, 3) == 0) i_data[WIDTH-1] = 1'b1;
          i_amt   = AMT_W'($urandom_range(0, 63));
          i_left  = 1'($urandom_range(0, 1));
          i_mode  = 2'($urandom_range(0, 3));
          e       = model(i_data, int'(i_amt), i_left, i_mode);
          exp_d   = e.d;
          exp_s   = e.s;
          i_valid = 1'b1;
          pend    = 1'b1;
        end else begin
          i_valid = 1'b0;
        end
      end
      i_ready = ($urandom_range(0, 9) < 7);
      step();
      if (in_fire_q) pend = 1'b0;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
Parametrised, pipelined successor to the 48-bit mantissa barrel shifter. It adds arithmetic and rotate modes, out-of-range amount handling and a sticky bit for rounding. A valid/ready handshake lets it sit between the mantissa multiplier and the normalise/round stages of the FP datapath.

Parameters:
WIDTH, 48, data width in bits; must be >= 4.
AMT_W, 6, shift-amount width; constraint 2^(AMT_W-1) < WIDTH <= 2^AMT_W (so 2^AMT_W < 2*WIDTH).
PIPE, 2, register stages (legal 1 or 2); equals latency in cycles when not stalled.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  input transaction valid
o_ready  output  1  block can accept input this cycle
i_data  input  WIDTH  operand
i_amt  input  AMT_W  shift amount, unsigned
i_left  input  1  1 = left, 0 = right
i_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_data  output  WIDTH  shifted result
o_sticky  output  1  OR of bits shifted out (see Behaviour)

Behaviour:
- Reset (async assert, sync release): all stage valids, o_valid, o_data and o_sticky = 0. Reset mid-flight drops all in-flight transactions, with no output.
- Transfer in when i_valid && o_ready. Transfer out when o_valid && i_ready.
- Each stage holds its data while its valid is set and the downstream stage is not advancing. A stage advances when it is empty or its successor advances.
- o_ready = !v0 || advance0. It is combinational from i_ready through the stage chain. No bubbles: throughput is 1 per cycle under continuous i_ready.
- o_data and o_sticky are held stable while o_valid && !i_ready.
- PIPE=2: stage 0 registers the operand after the upper ceil(AMT_W/2) shift levels plus the partial sticky; stage 1 applies the remaining levels and registers the result. PIPE=1: one output register only.
- Logical: zero fill. Amount >= WIDTH gives result 0 and sticky = OR of all i_data bits.
- Arithmetic right: fill with i_data[WIDTH-1]. Amount >= WIDTH gives all bits = sign. Arithmetic left is identical to logical left.
- Rotate: effective amount = i_amt, or i_amt - WIDTH when i_amt >= WIDTH (a single subtraction suffices by the AMT_W constraint). Sticky = 0 in rotate mode.
- Sticky: right shift = OR of the i_amt LSBs discarded. Left shift = OR of the MSBs discarded (overflow indicator). Amount 0 gives sticky = 0.
- Implementation: a single left ladder with bit-reversal at input and output for right shifts. The fill bit is an input to every level.

Optional Feature:
SHIFT_PIPE_STICKY_EN.
- Defined: sticky logic and its per-stage registers are built as specified.
- Undefined: o_sticky is tied to 0, no sticky logic or registers are built, and the data path is unchanged.

Test Plan:
- Reset: hold i_rst_n=0 with i_valid=1 -> o_valid=0, o_data=0, o_sticky=0. Deassert -> the first result appears exactly PIPE cycles after the first accepted input.
- Right logical, i_data=48'h8000_0000_0001, amt=1 -> o_data=48'h4000_0000_0000, o_sticky=1. Same input with amt=52 -> o_data=0, o_sticky=1.
- Arithmetic right, i_data=48'h8000_0000_0000, amt=4 -> 48'hF800_0000_0000, sticky=0. amt=50 -> 48'hFFFF_FFFF_FFFF.
- Rotate left, i_data=48'h8000_0000_0001, amt=1 -> 48'h0000_0000_0003. amt=49 -> 48'h0000_0000_0003. Rotate right, amt=1 -> 48'hC000_0000_0000. Sticky=0 in every rotate case.
- Backpressure: 4 back-to-back inputs (amt 0,1,2,3 on 48'h1 left) with i_ready=0 for 3 cycles -> o_ready drops once PIPE stages are full, o_data held at 48'h1. After release, outputs arrive in order 1, 2, 4, 8 with no loss or duplication.
- Reset mid-flight: assert i_rst_n=0 with 2 transactions in flight -> o_valid drops immediately (async). After release, none of those results appear.
